alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- EX-stage execution unit directly downstream of the ALU control decoder.
- Consumes the 3-bit ALU control code plus two 32-bit operands, and produces a registered result and zero flag.
- AND/OR/ADD/SUB complete in one cycle.
- MUL uses an iterative shift-add engine and raises a stall toward the hazard unit until the product is ready.
- Supports pipeline flush.

Parameters:
- WIDTH, 32, operand and result width.
- MUL_CYCLES, WIDTH, iteration count of the multiply engine (one multiplier bit per cycle).

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, reset, asynchronous, active-low.
- valid_i, input, 1, operation request present this cycle.
- ALUCtrl_i, input, 3, operation code from the ALU control decoder.
- data1_i, input, WIDTH, operand A (rs).
- data2_i, input, WIDTH, operand B (rt or sign-extended immediate).
- flush_i, input, 1, abort any in-flight operation.
- result_o, output, WIDTH, registered result.
- zero_o, output, 1, registered; 1 when result_o == 0.
- valid_o, output, 1, one-cycle pulse when result_o/zero_o carry a new result.
- err_o, output, 1, one-cycle pulse when an invalid op was accepted.
- stall_o, output, 1, high while the multiply engine is busy; the upstream stage holds its inputs.

Behaviour:
- Op encoding (shared package): AND=000, OR=001, ADD=010, MUL=011, SUB=110, INVALID_OP=111.
  - Codes 100 and 101 are also treated as invalid.
- Reset (rst_i low, asynchronous):
  - State goes to IDLE.
  - result_o=0, zero_o=1, valid_o=0, err_o=0, stall_o=0.
  - Iteration counter and multiply registers are cleared.
  - Reset mid-multiply discards the operation; no valid_o follows reset release.
- States:
  - IDLE: accepts a request.
  - MUL_RUN: iterates the multiply.
- Acceptance: at an edge where state==IDLE, valid_i=1 and flush_i=0.
- Single-cycle ops (AND, OR, ADD, SUB):
  - Result is registered at the accepting edge; valid_o=1 for the following cycle. Latency 1.
  - ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
- Invalid codes:
  - result_o=0, zero_o=1, valid_o=1 and err_o=1 for one cycle.
- MUL:
  - The accepting edge loads multiplicand=data1_i, multiplier=data2_i, accumulator=0 and count=0.
  - State goes to MUL_RUN; stall_o=1 from that edge.
  - Each MUL_RUN edge:
    - if the multiplier LSB is 1, accumulator += multiplicand;
    - multiplicand shifts left 1, multiplier shifts right 1, count++.
  - On the edge where count reaches MUL_CYCLES-1:
    - result_o = low WIDTH bits of the product (unsigned; identical to signed for the low half);
    - valid_o=1 next cycle, stall_o drops, state returns to IDLE.
  - Accept edge to valid_o = MUL_CYCLES edges (32 at default).
- While in MUL_RUN, valid_i and operands are ignored.
  - The next request can be accepted on the edge after stall_o falls, i.e. back-to-back with the MUL result.
- stall_o is registered, with no combinational path from inputs.
  - The hazard unit freezes IF/ID/EX on stall_o.
- flush_i:
  - In MUL_RUN: return to IDLE at the next edge, stall_o=0, no valid_o, result_o unchanged.
  - In IDLE: any simultaneous valid_i is not accepted (flush wins).
  - A valid_o pulse already scheduled for the current cycle is not retracted.
- Outputs between pulses:
  - result_o and zero_o hold their last value.
  - valid_o and err_o are 0.

Decomposition:
- Package alu_pkg holds WIDTH_DEFAULT and the 3-bit op-code localparams (AND, OR, ADD, MUL, SUB, INVALID_OP).
  - The ALU control decoder and this unit both import these encodings.
- Sub-module mul_iter holds the multiply engine: shift-add datapath, counter, start/done handshake.
  - It has its own flush and reset.
  - The top level holds the IDLE/MUL_RUN state, single-cycle ops, and output registers.

Test Plan:
- ADD: ADD, data1=0x00000005, data2=0x00000007, valid_i=1 for one cycle -> next cycle valid_o=1, result_o=0x0000000C, zero_o=0, stall_o=0.
- SUB, then wrap: SUB 9-9 -> result_o=0, zero_o=1. Then SUB 0-1 -> result_o=0xFFFFFFFF, zero_o=0.
- MUL with held request: MUL 0x00001234 × 0x00000100 -> stall_o=1 from the accept edge for 32 cycles.
  - valid_o pulses exactly 32 edges after acceptance with result_o=0x00123400.
  - A different ADD request held on the inputs during MUL_RUN is not executed until stall_o falls.
- MUL wrap, then back-to-back ADD: MUL 0xFFFFFFFF × 0xFFFFFFFF -> result_o=0x00000001.
  - The following ADD is accepted on the cycle stall_o falls.
- Invalid code: ALUCtrl_i=111 -> valid_o=1, err_o=1, result_o=0, zero_o=1.
- Flush and reset mid-multiply:
  - flush_i at iteration 10 of a MUL -> stall_o=0 next edge, no valid_o, result_o keeps its prior value.
  - rst_i low at iteration 5 -> all outputs at reset values immediately (asynchronously), no valid_o after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op-code encodings and EX-stage FSM state type.
// Imported by the ALU control decoder and by alu_exec_unit / mul_iter so the
// op-code values live in exactly one place.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // 3-bit ALU control codes; 100 and 101 are unused and treated as invalid
  localparam logic [2:0] AND        = 3'b000;
  localparam logic [2:0] OR         = 3'b001;
  localparam logic [2:0] ADD        = 3'b010;
  localparam logic [2:0] MUL        = 3'b011;
  localparam logic [2:0] SUB        = 3'b110;
  localparam logic [2:0] INVALID_OP = 3'b111;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } exec_state_t;

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// mul_iter: iterative shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i            - load operands and begin (ignored while flush_i is high)
//   flush_i            - abandon any multiply in progress
//   mcand_i, mplier_i  - operands captured on start
//   done_o             - high during the final iteration cycle (combinational)
//   product_o          - low WIDTH bits of the product, valid while done_o is high
module mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int             CW   = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(MUL_CYCLES - 1);

  logic             busy_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;

  // The final iteration's sum is handed straight to the caller so the product
  // is registered in the output stage on the same edge, not one later.
  assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign product_o = acc_next;
  assign done_o    = busy_reg && (count_reg == LAST) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (flush_i) begin
      busy_reg  <= 1'b0;
      count_reg <= '0;
    end else if (start_i) begin
      busy_reg   <= 1'b1;
      count_reg  <= '0;
      mcand_reg  <= mcand_i;
      mplier_reg <= mplier_i;
      acc_reg    <= '0;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CW'(1);
      if (count_reg == LAST) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execution unit fed by the ALU control decoder.
// Single-cycle AND/OR/ADD/SUB, iterative MUL with a registered stall toward the
// hazard unit, invalid-op error pulse, and pipeline flush.
// Ports:
//   clk_i, rst_i (async, active-low)
//   valid_i, ALUCtrl_i, data1_i, data2_i - operation request
//   flush_i                              - drop in-flight MUL / block acceptance
//   result_o, zero_o                     - registered result and zero flag (held)
//   valid_o, err_o                       - one-cycle pulses per completed op
//   stall_o                              - registered, high while MUL is running
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             err_o,
  output logic             stall_o
);

  exec_state_t      state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             stall_reg, stall_next;

  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] or_res;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
    assign and_res[gi] = data1_i[gi] & data2_i[gi];
    assign or_res[gi]  = data1_i[gi] | data2_i[gi];
  end

  mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .flush_i   (flush_i),
    .mcand_i   (data1_i),
    .mplier_i  (data2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    stall_next  = stall_reg;
    mul_start   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // flush beats a simultaneous request
        if (valid_i && !flush_i) begin
          case (ALUCtrl_i)
            AND: begin result_next = and_res;           valid_next = 1'b1; end
            OR:  begin result_next = or_res;            valid_next = 1'b1; end
            ADD: begin result_next = data1_i + data2_i; valid_next = 1'b1; end
            SUB: begin result_next = data1_i - data2_i; valid_next = 1'b1; end
            MUL: begin
              mul_start  = 1'b1;
              state_next = ST_MUL_RUN;
              stall_next = 1'b1;
            end
            default: begin
              result_next = '0;
              valid_next  = 1'b1;
              err_next    = 1'b1;
            end
          endcase
        end
      end
      ST_MUL_RUN: begin
        // request inputs are ignored here; upstream is frozen by stall_o
        if (flush_i) begin
          state_next = ST_IDLE;
          stall_next = 1'b0;
        end else if (mul_done) begin
          result_next = mul_product;
          valid_next  = 1'b1;
          state_next  = ST_IDLE;
          stall_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        stall_next = 1'b0;
      end
    endcase

    // result only changes together with a new result, so the flag stays in step
    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      stall_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
      stall_reg  <= stall_next;
    end
  end

  assign result_o = result_reg;
  assign zero_o   = zero_reg;
  assign valid_o  = valid_reg;
  assign err_o    = err_reg;
  assign stall_o  = stall_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: vector table, random ops against a reference
// model, and hand-written flush / reset sequences around a running multiply.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int MULC = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  alu_ctrl;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        valid_o;
  logic        err_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_unit #(.WIDTH(32), .MUL_CYCLES(MULC)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (alu_ctrl),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .flush_i   (flush_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o),
    .err_o     (err_o),
    .stall_o   (stall_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          edges;
    bit          hold;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic zero, input logic err,
                               input int edges, input bit hold);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.zero = zero; v.err = err;
    v.edges = edges; v.hold = hold;
    return v;
  endfunction

  // Reference: plain arithmetic on the operation's meaning, 32-bit wrap.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic e,
                                output int edges);
    logic [63:0] p;
    e = 1'b0;
    edges = 0;
    case (op)
      AND: r = a & b;
      OR:  r = a | b;
      ADD: r = a + b;
      SUB: r = a - b;
      MUL: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
        edges = MULC;
      end
      default: begin
        r = 32'h0;
        e = 1'b1;
      end
    endcase
    z = (r == 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request; returns the number of edges after the accept edge at
  // which valid_o became visible, and counts cycles where stall_o was wrong.
  task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit hold, output int edges, output logic [31:0] r,
                      output logic z, output logic e, output int stall_bad);
    @(negedge clk_i);
    valid_i = 1'b1; alu_ctrl = op; data1_i = a; data2_i = b; flush_i = 1'b0;
    @(posedge clk_i); #1;
    if (hold) begin
      alu_ctrl = ADD; data1_i = 32'd1; data2_i = 32'd2;
    end else begin
      valid_i = 1'b0;
    end
    edges = 0;
    stall_bad = 0;
    while (valid_o !== 1'b1 && edges < 100) begin
      if (stall_o !== 1'b1) stall_bad++;
      @(posedge clk_i); #1;
      edges++;
    end
    if (stall_o !== 1'b0) stall_bad++;
    r = result_o; z = zero_o; e = err_o;
  endtask

  task automatic run_check(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input logic [31:0] xr, input logic xz,
                           input logic xe, input int xedges);
    int edges, sbad;
    logic [31:0] r;
    logic z, e;
    exec(op, a, b, hold, edges, r, z, e, sbad);
    txn_no++;
    $display("txn %0d op=%b a=%h b=%h result=%h zero=%b err=%b edges=%0d",
             txn_no, op, a, b, r, z, e, edges);
    chk("latency", 32'(edges), 32'(xedges));
    chk("result", r, xr);
    chk("zero", {31'd0, z}, {31'd0, xz});
    chk("err", {31'd0, e}, {31'd0, xe});
    chk("stall_profile", 32'(sbad), 32'd0);
    @(posedge clk_i); #1;
    if (hold) begin
      // held ADD 1+2 must be taken on the edge right after the MUL result
      valid_i = 1'b0;
      chk("held_add_valid", {31'd0, valid_o}, 32'd1);
      chk("held_add_result", result_o, 32'd3);
      chk("held_add_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    chk("valid_drop", {31'd0, valid_o}, 32'd0);
    chk("err_drop", {31'd0, err_o}, 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, xr;
    logic        xz, xe;
    int          xedges, pulses;
    logic [31:0] prior;

    vecs[0]  = mkv(ADD, 32'h5, 32'h7, 32'hC, 1'b0, 1'b0, 0, 1'b0);
    vecs[1]  = mkv(SUB, 32'h9, 32'h9, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    vecs[2]  = mkv(SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
    vecs[3]  = mkv(AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 0, 1'b0);
    vecs[4]  = mkv(OR,  32'h0F00_0001, 32'h0000_F000, 32'h0F00_F001, 1'b0, 1'b0, 0, 1'b0);
    vecs[5]  = mkv(MUL, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 1'b0, 1'b0, MULC, 1'b1);
    vecs[6]  = mkv(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, MULC, 1'b1);
    vecs[7]  = mkv(INVALID_OP, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1, 0, 1'b0);
    vecs[8]  = mkv(3'b100, 32'hAAAA, 32'h5555, 32'h0, 1'b1, 1'b1, 0, 1'b0);
    vecs[9]  = mkv(3'b101, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1, 0, 1'b0);
    vecs[10] = mkv(ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0, 1'b0);

    rst_i = 1'b0; valid_i = 1'b0; alu_ctrl = ADD; data1_i = '0; data2_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_result", result_o, 32'h0);
    chk("reset_zero", {31'd0, zero_o}, 32'd1);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      run_check(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                vecs[i].res, vecs[i].zero, vecs[i].err, vecs[i].edges);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      model(op, a, b, xr, xz, xe, xedges);
      run_check(op, a, b, 1'b0, xr, xz, xe, xedges);
    end

    // Known non-zero result before the flush/reset sequences
    run_check(ADD, 32'h11, 32'h22, 1'b0, 32'h33, 1'b0, 1'b0, 0);
    prior = 32'h33;

    // Flush at iteration 10 of a MUL
    @(negedge clk_i);
    valid_i = 1'b1; alu_ctrl = MUL; data1_i = 32'h1234; data2_i = 32'h100;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("flush_mul_started", {31'd0, stall_o}, 32'd1);
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_result", result_o, prior);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1) pulses++;
    end
    chk("flush_no_late_valid", 32'(pulses), 32'd0);
    chk("flush_result_hold", result_o, prior);
    txn_no++;
    $display("txn %0d flushed MUL at iteration 10 result=%h", txn_no, result_o);

    // Flush in IDLE beats a simultaneous request
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; alu_ctrl = ADD; data1_i = 32'h1; data2_i = 32'h1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush_valid", {31'd0, valid_o}, 32'd0);
    chk("idle_flush_result", result_o, prior);
    txn_no++;
    $display("txn %0d flush with valid in IDLE result=%h", txn_no, result_o);

    // Asynchronous reset at iteration 5 of a MUL
    @(negedge clk_i);
    valid_i = 1'b1; alu_ctrl = MUL; data1_i = 32'h3; data2_i = 32'h5;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_result", result_o, 32'h0);
    chk("async_rst_zero", {31'd0, zero_o}, 32'd1);
    chk("async_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1) pulses++;
    end
    chk("rst_no_late_valid", 32'(pulses), 32'd0);
    chk("rst_stall_low", {31'd0, stall_o}, 32'd0);
    txn_no++;
    $display("txn %0d reset during MUL iteration 5 result=%h", txn_no, result_o);

    // Recovery after reset
    run_check(ADD, 32'h5, 32'h7, 1'b0, 32'hC, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
